quad_osc: RTL and testbench
===========================

QUAD_OSC -- requirements
Module: quad_osc

Interface
REQ-001 SHALL have parameters: WIDTH, default 8, sample width (signed two's complement); SHW, default 3, width of freq_sel; CW, default 12, period counter width; AMP, default 120, reset cosine value.
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: en  in  1  advance one rotation step; load  in  1  synchronous state load.
REQ-005 SHALL have ports: load_sin, load_cos  in  WIDTH  values applied by load.
REQ-006 SHALL have ports: freq_sel  in  SHW  requested shift k (step angle ~2^-k rad).
REQ-007 SHALL have ports: clr_sat  in  1  clears sat_flag.
REQ-008 SHALL have ports: sine, cos  out  WIDTH  registered samples; valid  out  1  one-cycle pulse per step.
REQ-009 SHALL have ports: zc  out  1  pulse on sine rising zero crossing; period  out  CW  samples between the last two zc; period_vld  out  1.
REQ-010 SHALL have ports: freq_act  out  SHW  shift currently in use; sat_flag  out  1  sticky clamp indicator.

Function
REQ-011 SHALL update on en (load low) with the Minsky rotation: s' = sat(s + (c >>> k)), c' = sat(c - (s' >>> k)), using arithmetic shifts, k = freq_act, and WIDTH+1-bit intermediates.
REQ-012 SHALL clamp each result to [-2^(WIDTH-1), 2^(WIDTH-1)-1] and set sat_flag when either clamps.
REQ-013 SHALL register sine/cos, giving 1-cycle latency from en to the new sample, with valid high that same cycle.
REQ-014 SHALL give load priority over en: next cycle sine=load_sin, cos=load_cos, valid=0, zc=0, and cycle counter, period_vld and IDLE state cleared.
REQ-015 SHALL assert zc for one cycle when a step moves sine from <0 to >=0.
REQ-016 SHALL count steps in a CW-bit counter; on zc: period <= count+1, count <= 0; the counter saturates at all-ones.
REQ-017 SHALL set period_vld on the second zc after reset or load.
REQ-018 SHALL use FSM states IDLE, RUN and PEND: IDLE->RUN on first en; RUN->PEND when freq_sel != freq_act; PEND->RUN on zc, freq_act <= freq_sel in the same cycle.
REQ-019 SHALL, while in IDLE, load freq_act from freq_sel directly.
REQ-020 SHALL drop a pending change if freq_sel returns to freq_act while in PEND.
REQ-021 SHALL clear count on a frequency change, and clear period_vld until two further zc.
REQ-022 SHALL hold all state when en is low, with valid=0.
REQ-023 SHALL apply clr_sat only when no new clamp occurs in the same cycle; a simultaneous clamp wins.

Reset
REQ-024 SHALL, on reset low, immediately set sine=0, cos=AMP, valid=0, zc=0, period=0, period_vld=0, count=0, freq_act=3, sat_flag=0, state=IDLE.
REQ-025 SHALL, when reset is asserted mid-operation, abort any pending frequency change and apply the REQ-024 values.

Structure
REQ-026 SHALL take FSM state encodings and default parameter values from a shared include/package, quad_osc_pkg.
REQ-027 SHALL instantiate sub-module quad_osc_sat (signed WIDTH+1 -> WIDTH clamp with overflow flag) twice, once for sine and once for cos.

Verification
REQ-028 Reset, then en for one cycle (WIDTH=8, k=3) -> sine=15, cos=119, valid=1, zc=0.
REQ-029 Free run at k=3 -> zc pulses; period matches the golden model and lies in 48..52; period_vld=1 after the second zc.
REQ-030 Load load_sin=100, load_cos=100, freq_sel=0, then one en -> sine=127, cos=-27, sat_flag=1; clr_sat -> sat_flag=0.
REQ-031 freq_sel changed 3->2 mid-cycle -> freq_act stays 3 until the next zc, then becomes 2; period_vld=0 until two further zc.
REQ-032 Load and en asserted together mid-run -> loaded values taken, no valid, counter cleared.
REQ-033 Reset pulsed low while in PEND -> outputs match REQ-024 asynchronously; no freq change applied afterwards.

Source files
------------

// File: rtl/quad_osc_pkg.sv
// Shared defaults and FSM encoding for the quadrature oscillator.
package quad_osc_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int SHW_DEF   = 3;
    localparam int CW_DEF    = 12;
    localparam int AMP_DEF   = 120;
    localparam int FREQ_RST  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

endpackage

// File: rtl/quad_osc_sat.sv
// Clamps a signed WIDTH+1 value into WIDTH bits and flags when clamping occurred.
module quad_osc_sat
    import quad_osc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic signed [WIDTH:0]   din,
    output logic signed [WIDTH-1:0] dout,
    output logic                    ovf
);

    localparam logic signed [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    // The value fits exactly when the two top bits agree.
    always_comb begin
        ovf  = din[WIDTH] != din[WIDTH-1];
        dout = din[WIDTH-1:0];
        if (ovf) begin
            dout = din[WIDTH] ? MIN_VAL : MAX_VAL;
        end
    end

endmodule

// File: rtl/quad_osc.sv
// Minsky-rotation quadrature oscillator with zero-crossing period measurement
// and frequency changes deferred to the next rising zero crossing.
module quad_osc
    import quad_osc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHW   = SHW_DEF,
    parameter int CW    = CW_DEF,
    parameter int AMP   = AMP_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    load,
    input  logic signed [WIDTH-1:0] load_sin,
    input  logic signed [WIDTH-1:0] load_cos,
    input  logic [SHW-1:0]          freq_sel,
    input  logic                    clr_sat,
    output logic signed [WIDTH-1:0] sine,
    output logic signed [WIDTH-1:0] cos,
    output logic                    valid,
    output logic                    zc,
    output logic [CW-1:0]           period,
    output logic                    period_vld,
    output logic [SHW-1:0]          freq_act,
    output logic                    sat_flag,
    output state_t                  dbg_state
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic signed [WIDTH:0]   s_ext, c_ext, sn_ext;
    logic signed [WIDTH:0]   s_sum, c_sum;
    logic signed [WIDTH-1:0] s_new, c_new;
    logic                    s_ovf, c_ovf;
    logic                    step, zc_next;
    logic [CW-1:0]           count;
    logic                    zc_seen;
    state_t                  state;

    // en is a one-shot request with no back-pressure: every accepted en
    // (load low) yields exactly one valid pulse on the following cycle.
    assign step    = en && !load;
    assign s_ext   = {sine[WIDTH-1], sine};
    assign c_ext   = {cos[WIDTH-1], cos};
    assign s_sum   = s_ext + (c_ext >>> freq_act);
    assign sn_ext  = {s_new[WIDTH-1], s_new};
    assign c_sum   = c_ext - (sn_ext >>> freq_act);
    assign zc_next = step && sine[WIDTH-1] && !s_new[WIDTH-1];

    quad_osc_sat #(.WIDTH(WIDTH)) u_sat_sin (.din(s_sum), .dout(s_new), .ovf(s_ovf));
    quad_osc_sat #(.WIDTH(WIDTH)) u_sat_cos (.din(c_sum), .dout(c_new), .ovf(c_ovf));

    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sine       <= '0;
            cos        <= WIDTH'(AMP);
            valid      <= 1'b0;
            zc         <= 1'b0;
            period     <= '0;
            period_vld <= 1'b0;
            count      <= '0;
            zc_seen    <= 1'b0;
            freq_act   <= SHW'(FREQ_RST);
            sat_flag   <= 1'b0;
            state      <= IDLE;
        end else begin
            valid <= 1'b0;
            zc    <= 1'b0;
            if (load) begin
                sine       <= load_sin;
                cos        <= load_cos;
                count      <= '0;
                zc_seen    <= 1'b0;
                period_vld <= 1'b0;
                freq_act   <= freq_sel;
                state      <= IDLE;
            end else begin
                if (step) begin
                    sine  <= s_new;
                    cos   <= c_new;
                    valid <= 1'b1;
                    zc    <= zc_next;
                    if (zc_next) begin
                        period  <= (count == CNT_MAX) ? CNT_MAX : count + CW'(1);
                        count   <= '0;
                        zc_seen <= 1'b1;
                        if (zc_seen) period_vld <= 1'b1;
                    end else if (count != CNT_MAX) begin
                        count <= count + CW'(1);
                    end
                end
                // Later assignments below override the step bookkeeping on a frequency change.
                case (state)
                    IDLE: begin
                        freq_act <= freq_sel;
                        if (step) state <= RUN;
                    end
                    RUN: begin
                        if (freq_sel != freq_act) state <= PEND;
                    end
                    PEND: begin
                        if (freq_sel == freq_act) begin
                            state <= RUN;
                        end else if (zc_next) begin
                            freq_act   <= freq_sel;
                            state      <= RUN;
                            count      <= '0;
                            zc_seen    <= 1'b0;
                            period_vld <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
            if (step && (s_ovf || c_ovf)) begin
                sat_flag <= 1'b1;
            end else if (clr_sat) begin
                sat_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_quad_osc.sv
// Directed bench for quad_osc: hand-computed vectors plus a small rotation model
// for free-running sequences, zero crossings and period values.
module tb_quad_osc;
    import quad_osc_pkg::*;

    localparam int W   = 8;
    localparam int SHW = 3;
    localparam int CW  = 12;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                en = 1'b0;
    logic                load = 1'b0;
    logic                clr_sat = 1'b0;
    logic signed [W-1:0] load_sin = '0;
    logic signed [W-1:0] load_cos = '0;
    logic [SHW-1:0]      freq_sel = 3'd3;
    logic signed [W-1:0] sine, cos;
    logic                valid, zc, period_vld, sat_flag;
    logic [CW-1:0]       period;
    logic [SHW-1:0]      freq_act;
    state_t              dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [2*W-1:0] exp_q[$];

    int m_s, m_c, m_k, m_idx, m_last, m_zcs, m_period, m_pend_k;
    bit m_pend, m_pvld;

    quad_osc dut (
        .clk(clk), .reset(reset), .en(en), .load(load),
        .load_sin(load_sin), .load_cos(load_cos), .freq_sel(freq_sel),
        .clr_sat(clr_sat), .sine(sine), .cos(cos), .valid(valid), .zc(zc),
        .period(period), .period_vld(period_vld), .freq_act(freq_act),
        .sat_flag(sat_flag), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat_w(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    task automatic model_reset(input int s, input int c, input int k);
        m_s = s; m_c = c; m_k = k;
        m_idx = 0; m_last = 0; m_zcs = 0;
        m_pvld = 0; m_pend = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One en cycle: predict with the model, then compare everything observable.
    task automatic run_step();
        int ns, nc;
        bit mzc;
        logic [2*W-1:0] e;
        ns  = sat_w(m_s + (m_c >>> m_k));
        nc  = sat_w(m_c - (ns >>> m_k));
        mzc = (m_s < 0) && (ns >= 0);
        m_idx++;
        if (mzc) begin
            m_period = m_idx - m_last;
            m_last   = m_idx;
            m_zcs++;
            if (m_zcs >= 2) m_pvld = 1;
            if (m_pend) begin
                m_k = m_pend_k; m_pend = 0; m_zcs = 0; m_pvld = 0;
            end
        end
        m_s = ns; m_c = nc;
        exp_q.push_back({ns[W-1:0], nc[W-1:0]});
        en = 1'b1;
        tick();
        en = 1'b0;
        e = exp_q.pop_front();
        check("step_sine", sine, $signed(e[2*W-1:W]));
        check("step_cos", cos, $signed(e[W-1:0]));
        check("step_valid", valid, 1);
        check("step_zc", zc, mzc);
        check("step_freq_act", freq_act, m_k);
        check("step_period_vld", period_vld, m_pvld);
        if (mzc) check("step_period", period, m_period);
    endtask

    initial begin
        // Asynchronous reset, checked before any clock edge.
        #1 reset = 1'b0;
        #2;
        check("rst_sine", sine, 0);
        check("rst_cos", cos, 120);
        check("rst_valid", valid, 0);
        check("rst_zc", zc, 0);
        check("rst_period", period, 0);
        check("rst_period_vld", period_vld, 0);
        check("rst_freq_act", freq_act, 3);
        check("rst_sat_flag", sat_flag, 0);
        check("rst_state", dbg_state, IDLE);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // First step at k=3.
        model_reset(0, 120, 3);
        run_step();
        check("first_sine", sine, 15);
        check("first_cos", cos, 119);
        check("first_state", dbg_state, RUN);

        // en low holds everything.
        tick();
        check("hold_valid", valid, 0);
        check("hold_sine", sine, 15);
        check("hold_cos", cos, 119);

        // Free run until two rising zero crossings.
        for (int i = 0; i < 200 && m_zcs < 2; i++) run_step();
        check("fr_zc_count", m_zcs, 2);
        check("fr_period_vld", period_vld, 1);
        check("fr_period_range", (period >= 48 && period <= 52), 1);

        // Frequency change requested mid-cycle waits for the next crossing.
        for (int i = 0; i < 5; i++) run_step();
        freq_sel = 3'd2;
        tick();
        check("fc_state_pend", dbg_state, PEND);
        check("fc_freq_hold", freq_act, 3);
        check("fc_idle_valid", valid, 0);
        m_pend = 1; m_pend_k = 2;
        for (int i = 0; i < 100 && m_pend; i++) run_step();
        check("fc_freq_new", freq_act, 2);
        check("fc_state_run", dbg_state, RUN);
        check("fc_pvld_cleared", period_vld, 0);
        for (int i = 0; i < 100 && m_zcs < 2; i++) run_step();
        check("fc_zc_count", m_zcs, 2);
        check("fc_pvld_back", period_vld, 1);

        // A pending request that reverts is dropped.
        freq_sel = 3'd3;
        tick();
        check("drop_state_pend", dbg_state, PEND);
        freq_sel = 3'd2;
        tick();
        check("drop_state_run", dbg_state, RUN);
        check("drop_freq_act", freq_act, 2);

        // load and en together: load wins, counter cleared.
        for (int i = 0; i < 3; i++) run_step();
        load = 1'b1; en = 1'b1;
        load_sin = 8'sd40; load_cos = -8'sd50;
        tick();
        load = 1'b0; en = 1'b0;
        check("ld_sine", sine, 40);
        check("ld_cos", cos, -50);
        check("ld_valid", valid, 0);
        check("ld_zc", zc, 0);
        check("ld_state", dbg_state, IDLE);
        check("ld_pvld", period_vld, 0);
        model_reset(40, -50, 2);
        for (int i = 0; i < 80 && m_zcs < 1; i++) run_step();
        check("ld_zc_count", m_zcs, 1);

        // Saturation with k=0, then clear, then clamp beating clear.
        load = 1'b1; load_sin = 8'sd100; load_cos = 8'sd100; freq_sel = 3'd0;
        tick();
        load = 1'b0;
        tick();
        check("sat_freq_act", freq_act, 0);
        en = 1'b1;
        tick();
        en = 1'b0;
        check("sat_sine", sine, 127);
        check("sat_cos", cos, -27);
        check("sat_flag_set", sat_flag, 1);
        check("sat_valid", valid, 1);
        clr_sat = 1'b1;
        tick();
        clr_sat = 1'b0;
        check("sat_flag_clr", sat_flag, 0);
        load = 1'b1;
        tick();
        load = 1'b0;
        en = 1'b1; clr_sat = 1'b1;
        tick();
        en = 1'b0; clr_sat = 1'b0;
        check("sat_clamp_wins", sat_flag, 1);

        // Reset while a frequency change is pending.
        freq_sel = 3'd3; load_sin = 8'sd0; load_cos = 8'sd120; load = 1'b1;
        tick();
        load = 1'b0;
        model_reset(0, 120, 3);
        for (int i = 0; i < 3; i++) run_step();
        freq_sel = 3'd2;
        tick();
        check("rp_state_pend", dbg_state, PEND);
        #2 reset = 1'b0;
        #1;
        check("rp_sine", sine, 0);
        check("rp_cos", cos, 120);
        check("rp_valid", valid, 0);
        check("rp_period", period, 0);
        check("rp_period_vld", period_vld, 0);
        check("rp_freq_act", freq_act, 3);
        check("rp_state", dbg_state, IDLE);
        freq_sel = 3'd3;
        #2 reset = 1'b1;
        model_reset(0, 120, 3);
        for (int i = 0; i < 80 && m_zcs < 1; i++) run_step();
        check("rp_zc_count", m_zcs, 1);
        check("rp_freq_final", freq_act, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
